chip8_sprite_draw: RTL and testbench
====================================

Name: chip8_sprite_draw

Overview:
- Executes the draw half of the CHIP-8 DXYN instruction.
- Reads N sprite bytes from main RAM starting at I, as a read-only master of the RAM port (12-bit address, registered 1-cycle read data).
- XORs each byte into a row-organised 64x32 monochrome framebuffer, one read-modify-write per row, and reports pixel collision for VF.
- Sits between the CPU execute stage and the RAM/framebuffer.

Parameters:
- SCR_W, 64, framebuffer width in pixels; must be 64.
- SCR_H, 32, framebuffer height in rows; must be a power of two.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  1-cycle request; sampled only in IDLE
- x  in  8  VX value; column = x mod 64
- y  in  8  VY value; row = y mod 32
- n  in  4  sprite height in bytes (0..15)
- i_addr  in  12  sprite base address (I register)
- busy  out  1  high while a draw is in progress
- done  out  1  1-cycle completion pulse
- collision  out  1  VF result; valid from done, held until next start
- mem_addr  out  12  RAM read address
- mem_din  in  8  RAM read data, valid the cycle after mem_addr
- fb_addr  out  5  framebuffer row address
- fb_rdata  in  64  framebuffer row data, valid the cycle after fb_addr; bit 63 = column 0
- fb_wdata  out  64  framebuffer row write data
- fb_we  out  1  framebuffer row write strobe

Behaviour:
- Reset: state IDLE; busy=0, done=0, fb_we=0, collision=0, mem_addr=0, fb_addr=0, fb_wdata=0. Reset mid-draw aborts immediately; no further writes.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE + start:
  - Latch x0 = x[5:0], y0 = y[4:0], n, base = i_addr; clear row counter r and collision.
  - n=0: go to DONE. Otherwise go to FETCH.
- FETCH (cycle t): mem_addr = (base + r) mod 4096; fb_addr = (y0 + r) mod 32. Next state WRITE.
- WRITE (cycle t+1):
  - Addresses held stable.
  - mask = mem_din placed at columns x0..x0+7; sprite bit 7 lands at column x0.
  - fb_wdata = fb_rdata ^ mask; fb_we=1 for this cycle only.
  - collision |= |(fb_rdata & mask).
  - r++; if r==n go to DONE, else FETCH.
- DONE: done=1 for one cycle; busy stays high; next state IDLE.
- busy is high from the cycle after start through the DONE cycle inclusive.
- Latency: draw of N rows = 2N+1 cycles from start to done (n=0: done on the cycle after start).
- Default wrap mode: columns wrap mod 64; rows wrap mod 32. Start coordinates are always reduced mod screen size.
- Arithmetic: mem_addr wraps at 4096 (i_addr=0xFFF, n=2 reads 0xFFF then 0x000). Row addition is 5-bit modular.
- start while busy: ignored. Inputs x/y/n/i_addr are read only on the accepted start cycle.

Optional Feature:
- Macro: CHIP8_SPRITE_CLIP_EN.
- Defined: pixels with x0+k >= 64 are dropped from the mask. Rows with y0+r >= 32 keep FETCH/WRITE timing but fb_we is suppressed and they contribute no collision.
- Undefined: full wrap behaviour described above.

Decomposition:
- chip8_pkg holds:
  - SCR_W/SCR_H constants.
  - Row/column address widths.
  - The draw state enum {IDLE, FETCH, WRITE, DONE}.
- One sub-module: chip8_sprite_mask. Combinational; byte + x0 (+ clip flag) -> 64-bit row mask; handles the rotate/clip.

Test Plan:
- Font '0' at i_addr=0x000, x=0, y=0, n=5 on a cleared framebuffer -> rows 0..4 bits[63:56] = F0,90,90,90,F0; collision=0; done 11 cycles after start.
- Redraw the same sprite at the same position -> rows 0..4 return to 0; collision=1.
- x=60, y=30, byte 0xFF, n=3 -> wrap mode: rows 30,31,0 get bits 63..60 and 3..0 set. CLIP_EN: only rows 30,31 bits 3..0 set; row 0 unwritten.
- n=0, start -> no fb_we; done on the next cycle; collision=0.
- i_addr=0xFFF, n=2 -> mem_addr sequence 0xFFF, 0x000; start pulsed while busy is ignored (exactly 2 fb_we pulses).
- rst asserted during the WRITE of row 1 of a 4-row draw -> next cycle busy=0, fb_we=0, collision=0; no further writes.

Source files
------------

// File: rtl/chip8_pkg.sv
// CHIP-8 sprite draw: shared screen geometry, request bundle and FSM states.
package chip8_pkg;

  localparam int SCR_W  = 64;
  localparam int SCR_H  = 32;
  localparam int COL_W  = $clog2(SCR_W);
  localparam int ROW_W  = $clog2(SCR_H);
  localparam int MEM_AW = 12;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } draw_state_t;

  typedef struct packed {
    logic [COL_W-1:0]  x0;
    logic [ROW_W-1:0]  y0;
    logic [3:0]        n;
    logic [MEM_AW-1:0] base;
  } draw_req_t;

endpackage

// File: rtl/chip8_sprite_mask.sv
// Places a sprite byte at column x0 of a 64-bit row (bit 63 = column 0).
// With clip set, pixels past the right edge are dropped instead of wrapped.
module chip8_sprite_mask
  import chip8_pkg::*;
(
  input  logic [7:0]       data,
  input  logic [COL_W-1:0] x0,
  input  logic             clip,
  output logic [SCR_W-1:0] mask
);

  logic [SCR_W-1:0]   row;
  logic [2*SCR_W-1:0] dbl;

  assign row = {data, {(SCR_W-8){1'b0}}};
  assign dbl = {row, row} >> x0;

  always_comb begin
    mask = dbl[SCR_W-1:0];
    if (clip) mask = row >> x0;
  end

endmodule

// File: rtl/chip8_sprite_draw.sv
// DXYN draw engine: one RAM fetch + one framebuffer row RMW per sprite row.
// Define CHIP8_SPRITE_CLIP_EN to clip at screen edges instead of wrapping.
module chip8_sprite_draw
  import chip8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [3:0]        n,
  input  logic [MEM_AW-1:0] i_addr,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_din,
  output logic [ROW_W-1:0]  fb_addr,
  input  logic [SCR_W-1:0]  fb_rdata,
  output logic [SCR_W-1:0]  fb_wdata,
  output logic              fb_we
);

  draw_state_t      state, state_nx;
  draw_req_t        req;
  logic [3:0]       r;
  logic [3:0]       r_inc;
  logic             coll_q;
  logic             clip;
  logic             row_ok;
  logic [ROW_W:0]   row_sum;
  logic [SCR_W-1:0] mask;
  logic             unused_hi;

`ifdef CHIP8_SPRITE_CLIP_EN
  assign clip = 1'b1;
`else
  assign clip = 1'b0;
`endif

  assign unused_hi = ^{x[7:COL_W], y[7:ROW_W]};

  assign r_inc    = r + 4'd1;
  assign row_sum  = {1'b0, req.y0} + {{(ROW_W-3){1'b0}}, r};
  assign row_ok   = ~(clip & row_sum[ROW_W]);
  assign mem_addr = req.base + {{(MEM_AW-4){1'b0}}, r};
  assign fb_addr  = row_sum[ROW_W-1:0];

  chip8_sprite_mask u_mask (
    .data (mem_din),
    .x0   (req.x0),
    .clip (clip),
    .mask (mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req    <= '0;
      r      <= '0;
      coll_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        req.x0   <= x[COL_W-1:0];
        req.y0   <= y[ROW_W-1:0];
        req.n    <= n;
        req.base <= i_addr;
        r        <= '0;
        coll_q   <= 1'b0;
      end else if (state == WRITE) begin
        r <= r_inc;
        if (row_ok) coll_q <= coll_q | (|(fb_rdata & mask));
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = (n == 4'd0) ? DONE : FETCH;
      FETCH: state_nx = WRITE;
      WRITE: state_nx = (r_inc == req.n) ? DONE : FETCH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    fb_we    = (state == WRITE) & row_ok;
    fb_wdata = '0;
    if (state == WRITE) fb_wdata = fb_rdata ^ mask;
  end

  assign collision = coll_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Directed bench for chip8_sprite_draw with behavioural RAM and framebuffer.
module tb_chip8_sprite_draw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic [3:0]  n = '0;
  logic [11:0] i_addr = '0;
  logic        busy, done, collision, fb_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic [4:0]  fb_addr;
  logic [63:0] fb_rdata, fb_wdata;

  logic [7:0]  ram [0:4095];
  logic [63:0] fb  [0:31];
  logic [11:0] alog [$];
  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int lat, w0, w1;

  chip8_sprite_draw dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .n(n),
    .i_addr(i_addr), .busy(busy), .done(done), .collision(collision),
    .mem_addr(mem_addr), .mem_din(mem_din), .fb_addr(fb_addr),
    .fb_rdata(fb_rdata), .fb_wdata(fb_wdata), .fb_we(fb_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din  <= ram[mem_addr];
    fb_rdata <= fb[fb_addr];
    if (fb_we) begin
      fb[fb_addr] <= fb_wdata;
      we_cnt++;
      alog.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic draw(input logic [7:0] xi, input logic [7:0] yi,
                      input logic [3:0] ni, input logic [11:0] ai,
                      input int poke, output int lt);
    @(negedge clk);
    start = 1'b1; x = xi; y = yi; n = ni; i_addr = ai;
    lt = 0;
    while (lt < 100) begin
      @(negedge clk);
      lt++;
      start = (lt == poke);
      if (lt == poke) begin
        n = 4'hF; i_addr = 12'h123; x = 8'h11; y = 8'h07;
      end
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    for (int j = 0; j < 32; j++) fb[j] = '0;
    ram[0] = 8'hF0; ram[1] = 8'h90; ram[2] = 8'h90;
    ram[3] = 8'h90; ram[4] = 8'hF0;
    ram[12'h100] = 8'hFF; ram[12'h101] = 8'hFF; ram[12'h102] = 8'hFF;
    ram[12'hFFF] = 8'h81;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_coll", collision, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_faddr", fb_addr, 0);
    chk("rst_wdata", fb_wdata, 0);
    rst = 1'b0;

    draw(8'd0, 8'd0, 4'd5, 12'h000, -1, lat);
    chk("font_lat", lat, 11);
    chk("font_busy_done", busy, 1);
    chk("font_coll", collision, 0);
    @(negedge clk);
    chk("font_idle", busy, 0);
    chk("font_r0", fb[0], {8'hF0, 56'h0});
    chk("font_r1", fb[1], {8'h90, 56'h0});
    chk("font_r2", fb[2], {8'h90, 56'h0});
    chk("font_r3", fb[3], {8'h90, 56'h0});
    chk("font_r4", fb[4], {8'hF0, 56'h0});
    chk("font_we", we_cnt, 5);

    draw(8'd0, 8'd0, 4'd5, 12'h000, -1, lat);
    chk("redraw_lat", lat, 11);
    chk("redraw_coll", collision, 1);
    @(negedge clk);
    chk("redraw_r0", fb[0], 0);
    chk("redraw_r2", fb[2], 0);
    chk("redraw_r4", fb[4], 0);

    w0 = we_cnt;
    draw(8'd5, 8'd5, 4'd0, 12'h200, -1, lat);
    chk("n0_lat", lat, 1);
    chk("n0_coll", collision, 0);
    chk("n0_we", we_cnt - w0, 0);

    draw(8'd124, 8'd62, 4'd3, 12'h100, -1, lat);
    chk("wrap_lat", lat, 7);
    chk("wrap_coll", collision, 0);
    @(negedge clk);
`ifdef CHIP8_SPRITE_CLIP_EN
    chk("clip_r30", fb[30], 64'h0000_0000_0000_000F);
    chk("clip_r31", fb[31], 64'h0000_0000_0000_000F);
    chk("clip_r0", fb[0], 64'h0);
`else
    chk("wrap_r30", fb[30], 64'hF000_0000_0000_000F);
    chk("wrap_r31", fb[31], 64'hF000_0000_0000_000F);
    chk("wrap_r0", fb[0], 64'hF000_0000_0000_000F);
`endif

    alog.delete();
    w0 = we_cnt;
    draw(8'd0, 8'd10, 4'd2, 12'hFFF, 2, lat);
    chk("memwrap_lat", lat, 5);
    chk("memwrap_n", alog.size(), 2);
    chk("memwrap_a0", alog[0], 12'hFFF);
    chk("memwrap_a1", alog[1], 12'h000);
    repeat (3) @(negedge clk);
    chk("ignore_busy", busy, 0);
    chk("ignore_we", we_cnt - w0, 2);
    chk("memwrap_r10", fb[10], {8'h81, 56'h0});
    chk("memwrap_r11", fb[11], {8'hF0, 56'h0});

    @(negedge clk);
    start = 1'b1; x = 8'd0; y = 8'd10; n = 4'd4; i_addr = 12'h000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_we0", fb_we, 1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_we1", fb_we, 1);
    chk("abort_coll_pre", collision, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_we", fb_we, 0);
    chk("abort_coll", collision, 0);
    rst = 1'b0;
    w1 = we_cnt;
    repeat (10) @(negedge clk);
    chk("abort_nowr", we_cnt, w1);
    chk("abort_r12", fb[12], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
